// File: rtl/mont_untrans_if.sv
// mont_untrans_if: request/response bundle for the inverse Montgomery transform.
//   i_start    : request strobe (host -> block)
//   i_a_mont   : Montgomery-domain operand (host -> block)
//   i_n        : odd modulus (host -> block)
//   o_a        : normal-domain result (block -> host)
//   o_finished : one-cycle completion pulse (block -> host)
//   o_busy     : operation in progress (block -> host)
interface mont_untrans_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic [WIDTH-1:0] i_a_mont;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_a;
  logic             o_finished;
  logic             o_busy;

  modport master (
    output i_start, i_a_mont, i_n,
    input  o_a, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_a_mont, i_n,
    output o_a, o_finished, o_busy
  );
endinterface

// File: rtl/mont_untrans.sv
// mont_untrans: inverse Montgomery transform, o_a = i_a_mont * 2^-WIDTH mod i_n.
// Bit-serial: WIDTH radix-2 reduction steps, one per cycle, then one
// conditional subtraction. Start accepted at E0 gives o_finished high in the
// cycle after edge E(WIDTH+1).
// Ports:
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : mont_untrans_if.slave (start/operands in, result/finished/busy out)
module mont_untrans #(
  parameter int WIDTH = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mont_untrans_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] a_reg;
  logic             finished_reg;
  logic [CW-1:0]    cnt_reg;

  // Reduction step: add n when r is odd so the sum is even, then halve.
  // The sum is kept WIDTH+1 bits wide so the carry lands in r[WIDTH-1].
  logic [WIDTH:0] sum;
  logic [WIDTH:0] step_val;
  assign sum      = {1'b0, r_reg} + (r_reg[0] ? {1'b0, n_reg} : '0);
  assign step_val = sum >> 1;

  // Final correction: a borrow out of the widened subtraction means r < n.
  logic [WIDTH:0] diff;
  logic           r_ge_n;
  assign diff   = {1'b0, r_reg} - {1'b0, n_reg};
  assign r_ge_n = ~diff[WIDTH];

  logic last_step;
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= S_IDLE;
      r_reg        <= '0;
      n_reg        <= '0;
      a_reg        <= '0;
      finished_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.i_start) begin
            r_reg     <= bus.i_a_mont;
            n_reg     <= bus.i_n;
            cnt_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          r_reg   <= step_val[WIDTH-1:0];
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) state_reg <= S_FIX;
        end
        S_FIX: begin
          a_reg        <= r_ge_n ? diff[WIDTH-1:0] : r_reg;
          finished_reg <= 1'b1;
          state_reg    <= S_DONE;
        end
        S_DONE: begin
          finished_reg <= 1'b0;
          state_reg    <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.o_a        = a_reg;
  assign bus.o_finished = finished_reg;
  assign bus.o_busy     = (state_reg != S_IDLE);
endmodule

// File: doc/mont_untrans.md
Name: mont_untrans

Overview:
Inverse Montgomery transform for the RSA datapath. It converts a Montgomery-domain value back to the normal domain: o_a = i_a_mont * 2^-WIDTH mod i_n.
It is the counterpart of the forward transform block and sits at the output of the modular-exponentiation chain, before the result is returned to the host.
It is bit-serial: one radix-2 Montgomery reduction step per cycle, followed by one final conditional subtraction.

Parameters:
WIDTH, 256, operand and modulus width in bits; also the Montgomery exponent (R = 2^WIDTH).

Ports:
i_clk  input  1  clock, rising-edge.
i_rst  input  1  reset, asynchronous, active-high.
i_start  input  1  request; sampled only in S_IDLE.
i_a_mont  input  WIDTH  Montgomery-domain operand; any value < 2^WIDTH.
i_n  input  WIDTH  modulus; must be odd.
o_a  output  WIDTH  result, registered; valid when o_finished=1, held until next accepted start.
o_finished  output  1  one-cycle completion pulse, registered.
o_busy  output  1  high in every state except S_IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=S_IDLE; o_a=0; o_finished=0; o_busy=0; iteration counter=0.
  - Latched operands cleared to 0.
  - No completion pulse is emitted for an aborted operation.
- States: S_IDLE, S_RUN, S_FIX, S_DONE.
- S_IDLE:
  - On a clock edge with i_start=1: latch i_a_mont into r, latch i_n into n_r, clear the counter, go to S_RUN.
  - i_a_mont and i_n may change after the accept edge; only the latched copies are used.
- S_RUN, one step per edge:
  - If r[0]=1: r <= (r + n_r) >> 1; otherwise r <= r >> 1.
  - The sum is computed WIDTH+1 bits wide, so the carry is shifted into r[WIDTH-1]. No truncation before the shift.
  - The counter increments each step. After exactly WIDTH steps (counter reaches WIDTH-1 on the final step edge), go to S_FIX.
  - Counter width: clog2(WIDTH)+1 bits.
- S_FIX, one edge:
  - If r >= n_r: o_a <= r - n_r; otherwise o_a <= r.
  - o_finished <= 1; go to S_DONE.
  - Invariant: r <= n_r entering S_FIX for any i_a_mont < 2^WIDTH, so a single subtraction suffices. r == n_r yields 0.
- S_DONE:
  - o_finished is high for exactly this one cycle.
  - Next edge: o_finished <= 0, state -> S_IDLE.
  - o_a keeps its value.
- Latency: start accepted at edge E0 -> o_finished high in the cycle following edge E(WIDTH+1). The next start is accepted at the earliest at edge E(WIDTH+3).
- i_start is ignored while o_busy=1: no restart, no relatch.
- Even i_n: result is undefined, but timing and the state sequence are unchanged and the FSM must still return to S_IDLE.
- Boundary values:
  - i_a_mont=0 -> o_a=0.
  - i_a_mont=i_n -> o_a=0.
  - i_a_mont >= i_n is legal and is reduced correctly.
- Round-trip requirement: feeding the forward transform output back into this block reproduces the original a (for a < n).

Test Plan:
- WIDTH=8, i_n=13, i_a_mont=6 -> o_a=5. o_finished pulses exactly once, 9 edges after the accept edge; o_busy high through S_DONE.
- WIDTH=8, i_n=13, inputs 1, 13, 255 in sequence -> outputs 3, 0, 11. Covers r==n in S_FIX and an input >= n. i_a_mont is changed the cycle after each accept with no effect on the result.
- WIDTH=256 round trip: a = 0x1234...ABCD, n = a 256-bit odd RSA modulus with MSB set. Forward transform result fed in -> o_a == a. Scoreboard checks 1000 random (a, n) pairs against a reference model.
- WIDTH=256, i_n = 2^256-1, i_a_mont = 2^256-1 -> o_a = 0. Exercises the carry into bit WIDTH of the sum.
- i_start held high for the whole operation -> exactly one completion per accepted start. The second accept happens only after S_DONE->S_IDLE, and o_a is unchanged until that result.
- Assert i_rst at step 100 of a WIDTH=256 run -> immediately o_busy=0, o_finished=0, o_a=0, and no pulse appears. A new start after reset gives the correct result with normal latency.
